// File: rtl/uart_word_packer.sv
// Packs received UART bytes into BYTES_PER_WORD-byte words and writes each completed word to RAM.
// Optional macro PACKER_TIMEOUT_EN flushes a partial word after TIMEOUT_CYCLES idle cycles.
module uart_word_packer #(
  parameter int BYTES_PER_WORD = 2,
  parameter int ADDR_WIDTH     = 5,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx_done,
  input  logic [7:0]                  data,
  input  logic                        clear,
  output logic                        ram_we,
  output logic [ADDR_WIDTH-1:0]       ram_wa,
  output logic [8*BYTES_PER_WORD-1:0] ram_din,
  output logic [ADDR_WIDTH:0]         word_count,
  output logic                        full,
  output logic                        overflow
);

  localparam int DW    = 8 * BYTES_PER_WORD;
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         buf_q, buf_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [DW-1:0]         din_q, din_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;

  logic [IDX_W-1:0]      lane_sel;
  logic [DW-1:0]         word_w;
  logic [DW-1:0]         commit_word;
  logic                  commit;

`ifdef PACKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_q, idle_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  assign lane_sel = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;

  always_comb begin
    idx_d       = idx_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    we_d        = 1'b0;
    wa_d        = wa_q;
    din_d       = din_q;
    cnt_d       = cnt_q;
    full_d      = full_q;
    ovf_d       = ovf_q;
    commit      = 1'b0;
`ifdef PACKER_TIMEOUT_EN
    idle_d      = idle_q;
`endif
    word_w = buf_q;
    for (int l = 0; l < BYTES_PER_WORD; l++) begin
      if (lane_sel == IDX_W'(l)) word_w[8*l +: 8] = data;
    end
    commit_word = word_w;

    if (clear) begin
      idx_d  = '0;
      addr_d = '0;
      buf_d  = '0;
      cnt_d  = '0;
      full_d = 1'b0;
      ovf_d  = 1'b0;
`ifdef PACKER_TIMEOUT_EN
      idle_d = '0;
`endif
    end else if (rx_done && full_q) begin
      ovf_d = 1'b1;
    end else if (rx_done) begin
      if (idx_q == LAST_IDX) begin
        commit = 1'b1;
      end else begin
        buf_d = word_w;
        idx_d = idx_q + 1'b1;
      end
`ifdef PACKER_TIMEOUT_EN
      idle_d = '0;
    end else if (idx_q != '0 && !full_q) begin
      // Unfilled lanes are already zero because the buffer is cleared after each word.
      if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        commit      = 1'b1;
        commit_word = buf_q;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
`endif
    end

    if (commit) begin
      we_d   = 1'b1;
      din_d  = commit_word;
      wa_d   = addr_q;
      idx_d  = '0;
      buf_d  = '0;
      cnt_d  = cnt_q + 1'b1;
`ifdef PACKER_TIMEOUT_EN
      idle_d = '0;
`endif
      // Address saturates at the last word; full blocks further writes.
      if (addr_q == ADDR_MAX) full_d = 1'b1;
      else                    addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      addr_q <= '0;
      buf_q  <= '0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      din_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef PACKER_TIMEOUT_EN
      idle_q <= '0;
`endif
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
      buf_q  <= buf_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      din_q  <= din_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
`ifdef PACKER_TIMEOUT_EN
      idle_q <= idle_d;
`endif
    end
  end

  assign ram_we     = we_q;
  assign ram_wa     = wa_q;
  assign ram_din    = din_q;
  assign word_count = cnt_q;
  assign full       = full_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// Scoreboard bench for uart_word_packer: three instances cover byte order, word size, full/overflow,
// clear, async reset and the optional idle-flush behaviour.
module tb_uart_word_packer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       rx0 = 0, rx1 = 0, rx2 = 0;
  logic [7:0] dt0 = 0, dt1 = 0, dt2 = 0;
  logic       cl0 = 0, cl1 = 0, cl2 = 0;

  logic        we0, we1, we2;
  logic [1:0]  wa0;
  logic [4:0]  wa1, wa2;
  logic [15:0] din0;
  logic [31:0] din1, din2;
  logic [2:0]  cnt0;
  logic [5:0]  cnt1, cnt2;
  logic        full0, full1, full2, ovf0, ovf1, ovf2;

  uart_word_packer #(.BYTES_PER_WORD(2), .ADDR_WIDTH(2), .MSB_FIRST(1), .TIMEOUT_CYCLES(16)) u_dut0 (
    .clk(clk), .reset(reset), .rx_done(rx0), .data(dt0), .clear(cl0),
    .ram_we(we0), .ram_wa(wa0), .ram_din(din0), .word_count(cnt0), .full(full0), .overflow(ovf0));

  uart_word_packer #(.BYTES_PER_WORD(4), .ADDR_WIDTH(5), .MSB_FIRST(0), .TIMEOUT_CYCLES(16)) u_dut1 (
    .clk(clk), .reset(reset), .rx_done(rx1), .data(dt1), .clear(cl1),
    .ram_we(we1), .ram_wa(wa1), .ram_din(din1), .word_count(cnt1), .full(full1), .overflow(ovf1));

  uart_word_packer #(.BYTES_PER_WORD(4), .ADDR_WIDTH(5), .MSB_FIRST(1), .TIMEOUT_CYCLES(16)) u_dut2 (
    .clk(clk), .reset(reset), .rx_done(rx2), .data(dt2), .clear(cl2),
    .ram_we(we2), .ram_wa(wa2), .ram_din(din2), .word_count(cnt2), .full(full2), .overflow(ovf2));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model state, one slot per instance
  int          cfg_bpw [3] = '{2, 4, 4};
  int          cfg_msb [3] = '{1, 0, 1};
  int          cfg_aw  [3] = '{2, 5, 5};
  int          m_idx [3];
  int          m_addr[3];
  int          m_cnt [3];
  logic [63:0] m_buf [3];
  logic        m_full[3];
  logic        m_ovf [3];

  typedef struct {
    int          a;
    logic [63:0] d;
  } wr_t;
  wr_t q0[$];
  wr_t q1[$];
  wr_t q2[$];

  task automatic push_wr(input int d, input int a, input logic [63:0] w);
    wr_t e;
    e.a = a;
    e.d = w;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic model_commit(input int d);
    push_wr(d, m_addr[d], m_buf[d]);
    m_cnt[d]++;
    if (m_addr[d] == (1 << cfg_aw[d]) - 1) m_full[d] = 1'b1;
    else                                   m_addr[d]++;
    m_idx[d] = 0;
    m_buf[d] = '0;
  endtask

  task automatic model_byte(input int d, input logic [7:0] b);
    int pos;
    if (m_full[d]) begin
      m_ovf[d] = 1'b1;
    end else begin
      pos = (cfg_msb[d] != 0) ? 8 * (cfg_bpw[d] - 1 - m_idx[d]) : 8 * m_idx[d];
      m_buf[d][pos +: 8] = b;
      if (m_idx[d] == cfg_bpw[d] - 1) model_commit(d);
      else                            m_idx[d]++;
    end
  endtask

  task automatic model_clear(input int d);
    m_idx[d]  = 0;
    m_addr[d] = 0;
    m_cnt[d]  = 0;
    m_buf[d]  = '0;
    m_full[d] = 1'b0;
    m_ovf[d]  = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) model_clear(d);
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // Drivers: entered and left at posedge+1
  task automatic send(input int d, input logic [7:0] b);
    case (d)
      0:       begin rx0 = 1'b1; dt0 = b; end
      1:       begin rx1 = 1'b1; dt1 = b; end
      default: begin rx2 = 1'b1; dt2 = b; end
    endcase
    model_byte(d, b);
    @(posedge clk);
    #1;
    rx0 = 1'b0;
    rx1 = 1'b0;
    rx2 = 1'b0;
  endtask

  task automatic do_clear0(input logic with_rx, input logic [7:0] b);
    rx0 = with_rx;
    dt0 = b;
    cl0 = 1'b1;
    model_clear(0);
    @(posedge clk);
    #1;
    rx0 = 1'b0;
    cl0 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_state0(input string t);
    chk({t, "_cnt0"},  cnt0,  m_cnt[0]);
    chk({t, "_full0"}, full0, m_full[0]);
    chk({t, "_ovf0"},  ovf0,  m_ovf[0]);
  endtask

  task automatic on_wr(input int d, input logic [63:0] wa, input logic [63:0] din, input logic fl);
    wr_t  e;
    logic empty;
    case (d)
      0:       empty = (q0.size() == 0);
      1:       empty = (q1.size() == 0);
      default: empty = (q2.size() == 0);
    endcase
    if (empty) begin
      chk($sformatf("d%0d_unexpected_we", d), 1, 0);
    end else begin
      case (d)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("d%0d_wa", d), wa, e.a);
      chk($sformatf("d%0d_din", d), din, e.d);
      chk($sformatf("d%0d_full_with_we", d), fl, e.a == (1 << cfg_aw[d]) - 1);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (we0) on_wr(0, wa0, din0, full0);
      if (we1) on_wr(1, wa1, din1, full1);
      if (we2) on_wr(2, wa2, din2, full2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we0", we0, 0);
    chk("rst_wa0", wa0, 0);
    chk("rst_din0", din0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_full0", full0, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_din1", din1, 0);
    reset = 1'b0;
    idle(1);

    // Two-byte MSB-first word
    send(0, 8'hAB);
    send(0, 8'hCD);
    idle(3);
    chk("t1_pending", q0.size(), 0);
    chk("t1_din_hold", din0, 16'hABCD);
    chk("t1_wa_hold", wa0, 0);
    chk_state0("t1");

    // Async reset mid-word, asserted between clock edges
    send(0, 8'hEE);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("arst_we0", we0, 0);
    chk("arst_din0", din0, 0);
    chk("arst_wa0", wa0, 0);
    chk("arst_cnt0", cnt0, 0);
    #3 reset = 1'b0;
    idle(1);
    send(0, 8'h12);
    send(0, 8'h34);
    idle(3);
    chk("arst_pending", q0.size(), 0);
    chk("arst_din_after", din0, 16'h1234);
    chk_state0("arst");

    // clear together with the second byte of a word
    send(0, 8'h55);
    do_clear0(1'b1, 8'h66);
    idle(2);
    chk_state0("clr_a");
    send(0, 8'h01);
    send(0, 8'h02);
    idle(3);
    chk("clr_pending", q0.size(), 0);
    chk("clr_din", din0, 16'h0102);
    chk("clr_wa", wa0, 0);
    chk_state0("clr_b");

    // Fill all four words, then overflow
    do_clear0(1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) send(0, 8'(i));
    idle(3);
    chk("full_pending", q0.size(), 0);
    chk("full_set", full0, 1);
    chk("full_cnt", cnt0, 4);
    chk("full_ovf_clear", ovf0, 0);
    send(0, 8'h09);
    send(0, 8'h0A);
    idle(3);
    chk("ovf_set", ovf0, 1);
    chk("ovf_wa_hold", wa0, 3);
    chk("ovf_din_hold", din0, 16'h0708);
    chk_state0("ovf");
    do_clear0(1'b0, 8'h00);
    chk_state0("ovf_clr");

    // Four-byte LSB-first words, back to back
    for (int i = 1; i <= 8; i++) send(1, 8'(8'h11 * i));
    idle(3);
    chk("lsb_pending", q1.size(), 0);
    chk("lsb_din_last", din1, 32'h88776655);
    chk("lsb_wa_last", wa1, 1);
    chk("lsb_cnt", cnt1, m_cnt[1]);

    // Partial word left idle
    send(2, 8'hA1);
    send(2, 8'hB2);
`ifdef PACKER_TIMEOUT_EN
    model_commit(2);
    idle(15);
    chk("to_not_early", q2.size(), 1);
    idle(3);
    chk("to_pending", q2.size(), 0);
    chk("to_din", din2, 32'hA1B20000);
    chk("to_cnt", cnt2, 1);
`else
    idle(40);
    chk("noto_cnt", cnt2, 0);
    chk("noto_din", din2, 0);
    chk("noto_pending", q2.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
